// File: rtl/logic_op_ctrl_if.sv
// Command/response bundle between the UART decoder/formatter and the bitwise-op sequencer.
interface logic_op_ctrl_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_use_acc;
  logic [N-1:0]     cmd_a;
  logic [N-1:0]     cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             res_zero;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Requester / consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, busy, op_count
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_use_acc, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, busy, op_count
  );
endinterface

// File: rtl/logic_op_ctrl.sv
// Sequencer for the N-bit AND/OR/XOR datapath: accept a command, evaluate for one
// cycle, hold the registered result until taken. Keeps an accumulator for chaining.
module logic_op_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  logic_op_ctrl_if.slave bus
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_valid_q, res_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [N-1:0]     and_c, or_c, xor_c, result_c;

  // Bitwise arrays, fed only from the latched operands
  assign and_c = a_q & b_q;
  assign or_c  = a_q | b_q;
  assign xor_c = a_q ^ b_q;

  // Select the array output for the latched op (LOAD passes B through)
  always_comb begin
    result_c = b_q;
    case (op_q)
      OP_AND:  result_c = and_c;
      OP_OR:   result_c = or_c;
      OP_XOR:  result_c = xor_c;
      OP_LOAD: result_c = b_q;
      default: result_c = b_q;
    endcase
  end

  // Next-state and next-output logic; flag outputs follow the next state
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    op_count_d = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d    = bus.cmd_op;
          a_d     = bus.cmd_use_acc ? acc_q : bus.cmd_a;
          b_d     = bus.cmd_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d = result_c;
        acc_d      = result_c;
        res_zero_d = (result_c == '0);
        if (op_count_q != '1) begin
          op_count_d = op_count_q + CNT_W'(1);
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_valid_q && bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any pending result and the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b1;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.busy      = busy_q;
  assign bus.op_count  = op_count_q;

endmodule
